cop0_irq_ctrl: RTL and testbench
================================

Name: cop0_irq_ctrl

Overview:
Parametrised coprocessor-0 interrupt/timer controller for the MIPS150 core. It is the successor to the fixed six-source COP0, with these additions:
- N external sources, each selectable as edge or level triggered.
- A nested interrupt-enable stack for RFE.
- A priority-encoded ExcCode.
- A vectored handler address output.

It sits beside the pipeline's MFC0/MTC0 path and drives the core's interrupt request and handler fetch address.

Parameters:
NUM_EXT, 4, number of external interrupt inputs (1..14); NUM_IRQ = NUM_EXT+2 is a localparam.
TIMER_WIDTH, 32, width of Count/Compare (8..32); reads are zero-extended to 32 bits.
VECTOR_BASE, 32'h0000_0180, handler base address.
VECTOR_STRIDE, 32'h20, byte spacing between per-source vectors.

Ports:
Clock  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
Enable  in  1  global clock enable; no state changes when low
DataAddress  in  5  CP0 register select
DataOut  out  32  combinational read data
DataInEnable  in  1  MTC0 write strobe
DataIn  in  32  MTC0 write data
InterruptedPC  in  32  PC to save into EPC
InterruptHandled  in  1  core took the interrupt this cycle
InterruptReturn  in  1  core executed RFE this cycle
IrqIn  in  NUM_EXT  asynchronous external requests
InterruptRequest  out  1  interrupt request to core
InterruptVector  out  32  handler address for the current winner

Behaviour:
- Register map:
  - 0x04 EPC (read-only to software).
  - 0x09 Count.
  - 0x0B Compare.
  - 0x0C Status: IM at bits [10 +: NUM_IRQ]; IEc at bit 0, IEp at bit 2, IEo at bit 4; all other bits read 0.
  - 0x0D Cause: IP at [10 +: NUM_IRQ]; ExcCode at [6:2]; all other bits 0.
  - 0x10 Mode: bit i=1 means source i is edge triggered; external sources only.
  - Any other address reads 32'h0.
- Source index map: 0..NUM_EXT-1 external; NUM_EXT = Count overflow; NUM_EXT+1 = timer match.
- Reset (asynchronous, Reset_n=0): EPC=0, Count=0, Compare=16'hFFFF truncated to TIMER_WIDTH, Status=0, IP=0, Mode=0, synchronisers=0. Outputs: InterruptRequest=0, InterruptVector=VECTOR_BASE.
- IrqIn synchronisation: 2-flop synchroniser, then a registered previous-value flop for edge detection.
- Level source: IP bit = synchronised level each cycle; software writes to that bit are ignored.
- Edge source:
  - IP sets on a synchronised 0->1 transition and stays set until software writes 0 to it via Cause.
  - Writing 1 has no effect.
  - A set event and a clear write in the same cycle leave the bit set.
- Timer match: IP[NUM_EXT+1] sets when Count==Compare. Any write to Compare clears it, unless a match occurs in that same cycle.
- Overflow: IP[NUM_EXT] sets when Count wraps from all-ones to 0. Cleared by writing 0 to it via Cause.
- Count increments by 1 every Enable cycle and wraps modulo 2^TIMER_WIDTH. An MTC0 to Count loads DataIn[TIMER_WIDTH-1:0] and suppresses that cycle's increment.
- Latency: an IrqIn rising edge produces InterruptRequest=1 on the 3rd Clock edge after IrqIn rises. A timer match is visible 1 edge later.
- InterruptRequest = IEc & |(IM & IP), combinational from flops.
- Priority: the highest index among (IM & IP) wins.
  - ExcCode = winner index.
  - InterruptVector = VECTOR_BASE + winner*VECTOR_STRIDE.
  - With no winner, ExcCode=0 and InterruptVector=VECTOR_BASE.
- InterruptHandled: EPC <= InterruptedPC; {IEo,IEp,IEc} <= {IEp,IEc,0}.
- InterruptReturn: {IEo,IEp,IEc} <= {IEo,IEo,IEp}.
- Simultaneous events:
  - Handled and Return together: Handled wins, Return is ignored.
  - MTC0 Status together with Handled or Return: the stack operation applies to the IE bits; IM takes DataIn.
  - MTC0 to other registers in the same cycle is unaffected.
- Enable low: all registers hold, including the synchronisers. DataOut and InterruptRequest still reflect the held state.

Decomposition:
- Package cop0_pkg:
  - Register address constants (CP0_EPC, CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_MODE).
  - Field LSB constants (IP_LSB=10, IM_LSB=10, EXC_LSB=2).
  - IE stack bit positions.
- One sub-module, irq_priority_enc: parametrised on NUM_IRQ; outputs a valid flag and a winner index. Each instance gets its own NUM_IRQ.

Test Plan:
- Reset_n pulsed mid-count (Count=0x1234): all registers clear asynchronously before the next Clock; Compare reads 0x0000FFFF; InterruptRequest=0.
- Level on source 1:
  - Stimulus: Status=0x0801|(1<<11); IrqIn[1] held high.
  - After 3 Clock edges: InterruptRequest=1, ExcCode=1, Vector=0x1A0.
  - Deassert IrqIn[1]: Request drops 3 edges later.
- Edge on source 0:
  - Stimulus: Mode=1, Status IE/IM0 set, 1-cycle pulse on IrqIn[0].
  - IP0 stays set after the pulse.
  - MTC0 Cause with bit10=0 clears it the next cycle.
- Timer:
  - Stimulus: Compare=20, Count=10, IM timer bit set.
  - Match 10 cycles later: IP[15]=1 (NUM_EXT=4), Vector=0x180+5*0x20=0x220.
  - MTC0 Compare clears IP[15].
- Nested IE stack:
  - IEc=1, Handled at PC=0x400: EPC=0x400, Status[4:0] pattern 00100.
  - Handled again, then Return twice: IEc restored to 1.
  - Handled+Return in the same cycle acts as Handled only.
- Priority and simultaneous events:
  - Sources 0, 2 and timer all pending and masked: ExcCode=5, Vector=0x220.
  - Mask timer off: ExcCode=2.
  - Count=all-ones with Enable: wraps to 0 and sets IP[14].

Source files
------------

// File: rtl/cop0_irq_ctrl_pkg.sv
// Shared constants and helpers for the COP0 interrupt/timer controller:
// CP0 register addresses, field positions and the RFE interrupt-enable stack.
package cop0_pkg;

    // CP0 register select values (DataAddress)
    localparam logic [4:0] CP0_EPC     = 5'h04;
    localparam logic [4:0] CP0_COUNT   = 5'h09;
    localparam logic [4:0] CP0_COMPARE = 5'h0B;
    localparam logic [4:0] CP0_STATUS  = 5'h0C;
    localparam logic [4:0] CP0_CAUSE   = 5'h0D;
    localparam logic [4:0] CP0_MODE    = 5'h10;

    // Field positions inside Status and Cause
    localparam int IP_LSB  = 10;
    localparam int IM_LSB  = 10;
    localparam int EXC_LSB = 2;
    localparam int EXC_W   = 5;

    // Interrupt-enable stack bit positions inside Status
    localparam int IEC_BIT = 0;
    localparam int IEP_BIT = 2;
    localparam int IEO_BIT = 4;

    // Three-deep interrupt-enable stack: current, previous, old
    typedef struct packed {
        logic ieo;
        logic iep;
        logic iec;
    } ie_stack_t;

    // Taking an interrupt pushes the stack and disables interrupts
    function automatic ie_stack_t ie_push(input ie_stack_t s);
        ie_stack_t r;
        r.ieo = s.iep;
        r.iep = s.iec;
        r.iec = 1'b0;
        return r;
    endfunction

    // RFE pops the stack; the old level is duplicated into previous
    function automatic ie_stack_t ie_pop(input ie_stack_t s);
        ie_stack_t r;
        r.ieo = s.ieo;
        r.iep = s.ieo;
        r.iec = s.iep;
        return r;
    endfunction

endpackage

// File: rtl/cop0_irq_ctrl_if.sv
// CP0 access and interrupt signalling between the pipeline (master) and the
// interrupt controller (slave).
interface cop0_irq_ctrl_if #(
    parameter int NUM_EXT = 4
);
    logic [4:0]         DataAddress;
    logic [31:0]        DataOut;
    logic               DataInEnable;
    logic [31:0]        DataIn;
    logic [31:0]        InterruptedPC;
    logic               InterruptHandled;
    logic               InterruptReturn;
    logic [NUM_EXT-1:0] IrqIn;
    logic               InterruptRequest;
    logic [31:0]        InterruptVector;

    modport master (
        output DataAddress, DataInEnable, DataIn, InterruptedPC,
               InterruptHandled, InterruptReturn, IrqIn,
        input  DataOut, InterruptRequest, InterruptVector
    );

    modport slave (
        input  DataAddress, DataInEnable, DataIn, InterruptedPC,
               InterruptHandled, InterruptReturn, IrqIn,
        output DataOut, InterruptRequest, InterruptVector
    );
endinterface

// File: rtl/cop0_irq_ctrl_priority_enc.sv
// Fixed-priority encoder: the highest-index asserted request wins.
// winner is zero when no request is asserted.
module irq_priority_enc #(
    parameter int NUM_IRQ = 6,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    // Scan upwards so later (higher) requests overwrite lower ones
    always_comb begin
        valid  = |req;
        winner = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) winner = IDX_W'(i);
        end
    end

endmodule

// File: rtl/cop0_irq_ctrl.sv
// COP0 interrupt/timer controller: external edge/level sources, Count/Compare
// timer with overflow, nested IE stack for RFE, priority ExcCode and vectored
// handler address.
module cop0_irq_ctrl
    import cop0_pkg::*;
#(
    parameter int          NUM_EXT       = 4,
    parameter int          TIMER_WIDTH   = 32,
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0180,
    parameter logic [31:0] VECTOR_STRIDE = 32'h20
) (
    input logic            Clock,
    input logic            Reset_n,
    input logic            Enable,
    cop0_irq_ctrl_if.slave bus
);

    localparam int NUM_IRQ = NUM_EXT + 2;
    localparam int IDX_W   = $clog2(NUM_IRQ);
    localparam int SRC_OVF = NUM_EXT;
    localparam int SRC_TMR = NUM_EXT + 1;
    localparam logic [TIMER_WIDTH-1:0] COMPARE_RST = TIMER_WIDTH'(32'h0000_FFFF);

    logic [NUM_EXT-1:0]     sync1_q, sync1_d;
    logic [NUM_EXT-1:0]     sync2_q, sync2_d;
    logic [NUM_EXT-1:0]     prev_q, prev_d;
    logic [NUM_EXT-1:0]     mode_q, mode_d;
    logic [NUM_IRQ-1:0]     ip_q, ip_d;
    logic [NUM_IRQ-1:0]     im_q, im_d;
    ie_stack_t              ie_q, ie_d;
    logic [31:0]            epc_q, epc_d;
    logic [TIMER_WIDTH-1:0] count_q, count_d;
    logic [TIMER_WIDTH-1:0] compare_q, compare_d;

    logic                   wr_count, wr_compare, wr_status, wr_cause, wr_mode;
    logic [NUM_EXT-1:0]     rise;
    logic                   wrap, match;
    logic                   pend_valid;
    logic [IDX_W-1:0]       winner;
    logic [EXC_W-1:0]       exc_code;
    logic                   unused_data_in;

    assign wr_count   = bus.DataInEnable && (bus.DataAddress == CP0_COUNT);
    assign wr_compare = bus.DataInEnable && (bus.DataAddress == CP0_COMPARE);
    assign wr_status  = bus.DataInEnable && (bus.DataAddress == CP0_STATUS);
    assign wr_cause   = bus.DataInEnable && (bus.DataAddress == CP0_CAUSE);
    assign wr_mode    = bus.DataInEnable && (bus.DataAddress == CP0_MODE);

    assign rise  = sync2_q & ~prev_q;
    assign match = (count_q == compare_q);
    assign wrap  = !wr_count && (count_q == '1);

    // Upper DataIn bits only matter for some parameter choices
    assign unused_data_in = ^bus.DataIn;

    // Next-state logic for every register; nothing moves while Enable is low
    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block leaves a variable unassigned (no latches).
        sync1_d   = sync1_q;
        sync2_d   = sync2_q;
        prev_d    = prev_q;
        mode_d    = mode_q;
        ip_d      = ip_q;
        im_d      = im_q;
        ie_d      = ie_q;
        epc_d     = epc_q;
        count_d   = count_q;
        compare_d = compare_q;

        if (Enable) begin
            sync1_d = bus.IrqIn;
            sync2_d = sync1_q;
            prev_d  = sync2_q;

            // A software load of Count replaces that cycle's increment
            if (wr_count) count_d = bus.DataIn[TIMER_WIDTH-1:0];
            else          count_d = count_q + TIMER_WIDTH'(1);

            if (wr_compare) compare_d = bus.DataIn[TIMER_WIDTH-1:0];
            if (wr_mode)    mode_d    = bus.DataIn[NUM_EXT-1:0];

            // External sources: edge bits are sticky (set beats clear), level bits track the pin
            for (int i = 0; i < NUM_EXT; i++) begin
                if (mode_q[i]) begin
                    if (rise[i])                                   ip_d[i] = 1'b1;
                    else if (wr_cause && !bus.DataIn[IP_LSB + i])  ip_d[i] = 1'b0;
                end else begin
                    ip_d[i] = sync2_q[i];
                end
            end

            if (wrap)                                            ip_d[SRC_OVF] = 1'b1;
            else if (wr_cause && !bus.DataIn[IP_LSB + SRC_OVF])  ip_d[SRC_OVF] = 1'b0;

            if (match)           ip_d[SRC_TMR] = 1'b1;
            else if (wr_compare) ip_d[SRC_TMR] = 1'b0;

            // IM always takes the write; a stack operation overrides the written IE bits
            if (wr_status) begin
                im_d    = bus.DataIn[IM_LSB +: NUM_IRQ];
                ie_d.ieo = bus.DataIn[IEO_BIT];
                ie_d.iep = bus.DataIn[IEP_BIT];
                ie_d.iec = bus.DataIn[IEC_BIT];
            end

            if (bus.InterruptHandled) begin
                ie_d  = ie_push(ie_q);
                epc_d = bus.InterruptedPC;
            end else if (bus.InterruptReturn) begin
                ie_d  = ie_pop(ie_q);
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            mode_q    <= '0;
            ip_q      <= '0;
            im_q      <= '0;
            ie_q      <= '0;
            epc_q     <= '0;
            count_q   <= '0;
            compare_q <= COMPARE_RST;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            mode_q    <= mode_d;
            ip_q      <= ip_d;
            im_q      <= im_d;
            ie_q      <= ie_d;
            epc_q     <= epc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end

    irq_priority_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req    (im_q & ip_q),
        .valid  (pend_valid),
        .winner (winner)
    );

    assign exc_code             = EXC_W'(winner);
    assign bus.InterruptRequest = ie_q.iec & pend_valid;
    assign bus.InterruptVector  = VECTOR_BASE + 32'(winner) * VECTOR_STRIDE;

    // Combinational CP0 read mux; unmapped addresses read zero
    always_comb begin
        bus.DataOut = '0;
        case (bus.DataAddress)
            CP0_EPC:     bus.DataOut = epc_q;
            CP0_COUNT:   bus.DataOut = 32'(count_q);
            CP0_COMPARE: bus.DataOut = 32'(compare_q);
            CP0_STATUS: begin
                bus.DataOut[IM_LSB +: NUM_IRQ] = im_q;
                bus.DataOut[IEO_BIT]           = ie_q.ieo;
                bus.DataOut[IEP_BIT]           = ie_q.iep;
                bus.DataOut[IEC_BIT]           = ie_q.iec;
            end
            CP0_CAUSE: begin
                bus.DataOut[IP_LSB +: NUM_IRQ] = ip_q;
                bus.DataOut[EXC_LSB +: EXC_W]  = exc_code;
            end
            CP0_MODE:    bus.DataOut = 32'(mode_q);
            default:     bus.DataOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cop0_irq_ctrl.sv
// Scoreboard bench for cop0_irq_ctrl (NUM_EXT=4): stimulus pushes expected
// observations into a queue, a negedge monitor pops and compares them.
module tb_cop0_irq_ctrl;
    import cop0_pkg::*;

    typedef enum int {K_RD, K_IRQ, K_VEC} kind_e;

    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] exp;
    } exp_t;

    logic Clock = 1'b0;
    logic Reset_n;
    logic Enable;
    logic rd_valid = 1'b0;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    cop0_irq_ctrl_if #(.NUM_EXT(4)) bus ();

    cop0_irq_ctrl #(
        .NUM_EXT       (4),
        .TIMER_WIDTH   (32),
        .VECTOR_BASE   (32'h0000_0180),
        .VECTOR_STRIDE (32'h20)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Enable  (Enable),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    // Monitor: whenever the stimulus presents an observation, pop and compare
    always @(negedge Clock) begin
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: observation with empty queue");
            end else begin
                exp_t        e;
                logic [31:0] act;
                e = sb_q.pop_front();
                case (e.kind)
                    K_RD:    act = bus.DataOut;
                    K_IRQ:   act = 32'(bus.InterruptRequest);
                    default: act = bus.InterruptVector;
                endcase
                n_cmp++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.DataAddress  = addr;
        bus.DataIn       = data;
        bus.DataInEnable = 1'b1;
        tick();
        bus.DataInEnable = 1'b0;
    endtask

    // Observe the current state; Enable is dropped across any edge crossed so state is frozen
    task automatic observe(input string name, input kind_e kind, input logic [4:0] addr,
                           input logic [31:0] exp);
        exp_t e;
        logic en_save;
        en_save         = Enable;
        Enable          = 1'b0;
        bus.DataAddress = addr;
        e.name = name;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
        rd_valid = 1'b1;
        @(negedge Clock);
        #1;
        rd_valid = 1'b0;
        Enable   = en_save;
    endtask

    task automatic chk_rd(input string name, input logic [4:0] addr, input logic [31:0] exp);
        observe(name, K_RD, addr, exp);
    endtask

    task automatic chk_irq(input string name, input logic exp);
        observe(name, K_IRQ, 5'h00, 32'(exp));
    endtask

    task automatic chk_vec(input string name, input logic [31:0] exp);
        observe(name, K_VEC, 5'h00, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n              = 1'b0;
        Enable               = 1'b1;
        bus.DataAddress      = '0;
        bus.DataIn           = '0;
        bus.DataInEnable     = 1'b0;
        bus.InterruptedPC    = '0;
        bus.InterruptHandled = 1'b0;
        bus.InterruptReturn  = 1'b0;
        bus.IrqIn            = '0;
        tick(2);
        Reset_n = 1'b1;

        // Reset asserted mid-count clears everything before the next edge
        mtc0(CP0_COUNT, 32'h1234);
        chk_rd("count_loaded", CP0_COUNT, 32'h1234);
        Reset_n = 1'b0;
        chk_rd("rst_count",   CP0_COUNT,   32'h0);
        chk_rd("rst_compare", CP0_COMPARE, 32'h0000_FFFF);
        chk_rd("rst_status",  CP0_STATUS,  32'h0);
        chk_rd("rst_cause",   CP0_CAUSE,   32'h0);
        chk_rd("rst_epc",     CP0_EPC,     32'h0);
        chk_rd("rst_mode",    CP0_MODE,    32'h0);
        chk_rd("rst_unmapped", 5'h1F,      32'h0);
        chk_irq("rst_irq", 1'b0);
        chk_vec("rst_vec", 32'h180);
        Reset_n = 1'b1;

        // Level source 1: request on the 3rd edge, drops 3 edges after release
        mtc0(CP0_STATUS, 32'h0801);
        bus.IrqIn = 4'b0010;
        tick(2);
        chk_irq("lvl_irq_edge2", 1'b0);
        tick(1);
        chk_irq("lvl_irq_edge3", 1'b1);
        chk_rd("lvl_cause", CP0_CAUSE, 32'h0804);
        chk_vec("lvl_vec", 32'h1A0);
        bus.IrqIn = 4'b0000;
        tick(2);
        chk_irq("lvl_hold_edge2", 1'b1);
        tick(1);
        chk_irq("lvl_drop_edge3", 1'b0);

        // Edge source 0: one-cycle pulse latches IP0 until software clears it
        mtc0(CP0_MODE, 32'h1);
        mtc0(CP0_STATUS, 32'h0401);
        bus.IrqIn = 4'b0001;
        tick();
        bus.IrqIn = 4'b0000;
        tick();
        chk_irq("edge_irq_edge2", 1'b0);
        tick();
        chk_irq("edge_irq_edge3", 1'b1);
        tick(3);
        chk_rd("edge_sticky", CP0_CAUSE, 32'h0400);
        chk_vec("edge_vec", 32'h180);
        mtc0(CP0_CAUSE, 32'h0);
        chk_rd("edge_cleared", CP0_CAUSE, 32'h0);
        chk_irq("edge_irq_cleared", 1'b0);
        mtc0(CP0_CAUSE, 32'h0400);
        chk_rd("edge_write1_noop", CP0_CAUSE, 32'h0);

        // Timer match: Compare=20, Count=10, match visible one edge after Count==Compare
        mtc0(CP0_STATUS, 32'h8001);
        mtc0(CP0_COUNT, 32'd10);
        mtc0(CP0_COMPARE, 32'd20);
        tick(9);
        chk_rd("tmr_count20", CP0_COUNT, 32'd20);
        chk_rd("tmr_not_yet", CP0_CAUSE, 32'h0);
        tick(1);
        chk_rd("tmr_cause", CP0_CAUSE, 32'h8014);
        chk_irq("tmr_irq", 1'b1);
        chk_vec("tmr_vec", 32'h220);
        mtc0(CP0_COMPARE, 32'd100);
        chk_rd("tmr_cleared", CP0_CAUSE, 32'h0);

        // Nested IE stack
        mtc0(CP0_STATUS, 32'h0001);
        bus.InterruptedPC    = 32'h400;
        bus.InterruptHandled = 1'b1;
        tick();
        bus.InterruptHandled = 1'b0;
        chk_rd("ie_h1_status", CP0_STATUS, 32'h04);
        chk_rd("ie_h1_epc", CP0_EPC, 32'h400);
        bus.InterruptedPC    = 32'h500;
        bus.InterruptHandled = 1'b1;
        tick();
        bus.InterruptHandled = 1'b0;
        chk_rd("ie_h2_status", CP0_STATUS, 32'h10);
        bus.InterruptReturn = 1'b1;
        tick();
        bus.InterruptReturn = 1'b0;
        chk_rd("ie_r1_status", CP0_STATUS, 32'h14);
        bus.InterruptReturn = 1'b1;
        tick();
        bus.InterruptReturn = 1'b0;
        chk_rd("ie_r2_status", CP0_STATUS, 32'h15);
        bus.InterruptedPC    = 32'h600;
        bus.InterruptHandled = 1'b1;
        bus.InterruptReturn  = 1'b1;
        tick();
        bus.InterruptHandled = 1'b0;
        bus.InterruptReturn  = 1'b0;
        chk_rd("ie_hr_status", CP0_STATUS, 32'h14);
        chk_rd("ie_hr_epc", CP0_EPC, 32'h600);
        bus.DataAddress      = CP0_STATUS;
        bus.DataIn           = 32'h0C00;
        bus.DataInEnable     = 1'b1;
        bus.InterruptHandled = 1'b1;
        tick();
        bus.DataInEnable     = 1'b0;
        bus.InterruptHandled = 1'b0;
        chk_rd("ie_mtc0_handled", CP0_STATUS, 32'h0C10);

        // Priority: sources 0, 2 and timer pending together
        mtc0(CP0_MODE, 32'h0);
        mtc0(CP0_STATUS, 32'h9401);
        bus.IrqIn = 4'b0101;
        mtc0(CP0_COMPARE, 32'd50);
        mtc0(CP0_COUNT, 32'd50);
        tick(2);
        chk_rd("prio_cause", CP0_CAUSE, 32'h9414);
        chk_vec("prio_vec", 32'h220);
        mtc0(CP0_STATUS, 32'h1401);
        chk_rd("prio_masked_cause", CP0_CAUSE, 32'h9408);
        chk_vec("prio_masked_vec", 32'h1C0);
        chk_irq("prio_masked_irq", 1'b1);

        // Count overflow sets IP[14]; Cause write of 0 clears it
        mtc0(CP0_COUNT, 32'hFFFF_FFFF);
        chk_rd("ovf_allones", CP0_COUNT, 32'hFFFF_FFFF);
        tick();
        chk_rd("ovf_wrapped", CP0_COUNT, 32'h0);
        chk_rd("ovf_cause", CP0_CAUSE, 32'hD408);
        mtc0(CP0_CAUSE, 32'h0);
        chk_rd("ovf_cleared", CP0_CAUSE, 32'h9408);

        // Enable low freezes all state
        Enable = 1'b0;
        bus.IrqIn = 4'b0000;
        tick(5);
        chk_rd("hold_count", CP0_COUNT, 32'h1);
        chk_rd("hold_cause", CP0_CAUSE, 32'h9408);
        Enable = 1'b1;

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge Clock);
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d observations left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
